// File: rtl/sample_feeder_if.sv
// Neuron-side handshake bundle between sample_feeder and the neuron.
//   master (feeder): drives x1_out/x2_out/t_out/data_ready/n_out,
//                    receives request_flag/neuron_done.
//   slave  (neuron): the mirror image.
interface sample_feeder_if #(
    parameter int XW = 7,
    parameter int TW = 2
);
    logic          request_flag;
    logic          neuron_done;
    logic [XW-1:0] x1_out;
    logic [XW-1:0] x2_out;
    logic [TW-1:0] t_out;
    logic          data_ready;
    logic [31:0]   n_out;

    modport master (
        input  request_flag,
        input  neuron_done,
        output x1_out,
        output x2_out,
        output t_out,
        output data_ready,
        output n_out
    );

    modport slave (
        output request_flag,
        output neuron_done,
        input  x1_out,
        input  x2_out,
        input  t_out,
        input  data_ready,
        input  n_out
    );
endinterface

// File: rtl/sample_feeder.sv
// sample_feeder: stores the training set (x1, x2, t) and streams it to the
// neuron over the request_flag/data_ready handshake, looping epochs until the
// neuron reports done. Also publishes the stored sample count as n_out.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous reset, active-low
//   clear      synchronous: empty the store, return to IDLE
//   load_en    write load_x1/load_x2/load_t at index count (IDLE only)
//   load_full  store holds DEPTH samples
//   start      begin/restart streaming from index 0
//   nif        neuron handshake (request_flag, neuron_done in;
//              x1_out, x2_out, t_out, data_ready, n_out out)
//   epoch      completed passes, saturating
//   busy       streaming (WAIT_REQ or PRESENT)
//   finished   neuron reported done
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accept loads, wait for start with a non-empty store
// WAIT_REQ | wait for request_flag (or neuron_done)
// PRESENT  | one-cycle strobe of data_ready, advance idx/epoch
// DONE     | hold last sample, wait for start to rerun
module sample_feeder #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int XW    = 7,
    parameter int TW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load_en,
    input  logic [XW-1:0]         load_x1,
    input  logic [XW-1:0]         load_x2,
    input  logic [TW-1:0]         load_t,
    output logic                  load_full,
    input  logic                  start,
    sample_feeder_if.master       nif,
    output logic [15:0]           epoch,
    output logic                  busy,
    output logic                  finished
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_REQ = 2'd1;
    localparam logic [1:0] S_PRESENT  = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    localparam int SW = XW + XW + TW;
    localparam logic [AW:0] DEPTH_CNT = AW'(DEPTH) == '0 ? {1'b1, {AW{1'b0}}} : (AW+1)'(DEPTH);

    logic [1:0]    state;
    logic [AW:0]   count;
    logic [AW-1:0] idx;
    logic [XW-1:0] x1_q;
    logic [XW-1:0] x2_q;
    logic [TW-1:0] t_q;
    logic          data_ready_q;

    logic [SW-1:0] mem [DEPTH];
    logic [SW-1:0] rd_word;
    logic          mem_we;
    logic          last_idx;

    assign load_full = (count == DEPTH_CNT);
    assign busy      = (state == S_WAIT_REQ) || (state == S_PRESENT);
    assign finished  = (state == S_DONE);

    // Write happens on the same edge that advances count, so the word lands
    // at the pre-increment index.
    assign mem_we   = rst && !clear && (state == S_IDLE) && load_en && !load_full;
    assign rd_word  = mem[idx];
    assign last_idx = ({1'b0, idx} == (count - 1'b1));

    // Sample store is deliberately not reset; count alone defines validity.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[count[AW-1:0]] <= {load_x1, load_x2, load_t};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            count        <= '0;
            idx          <= '0;
            epoch        <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            t_q          <= '0;
            data_ready_q <= 1'b0;
        end else if (clear) begin
            state        <= S_IDLE;
            count        <= '0;
            idx          <= '0;
            epoch        <= '0;
            data_ready_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_en && !load_full) begin
                        count <= count + 1'b1;
                    end
                    // start looks at the count before any same-cycle load.
                    if (start && (count != '0)) begin
                        idx   <= '0;
                        epoch <= '0;
                        state <= S_WAIT_REQ;
                    end
                end
                S_WAIT_REQ: begin
                    if (nif.neuron_done) begin
                        state <= S_DONE;
                    end else if (nif.request_flag) begin
                        x1_q         <= rd_word[SW-1 -: XW];
                        x2_q         <= rd_word[TW+XW-1 -: XW];
                        t_q          <= rd_word[TW-1:0];
                        data_ready_q <= 1'b1;
                        state        <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    data_ready_q <= 1'b0;
                    if (last_idx) begin
                        idx <= '0;
                        if (epoch != 16'hFFFF) begin
                            epoch <= epoch + 16'd1;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                    state <= nif.neuron_done ? S_DONE : S_WAIT_REQ;
                end
                S_DONE: begin
                    if (start) begin
                        idx   <= '0;
                        epoch <= '0;
                        state <= S_WAIT_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign nif.x1_out     = x1_q;
    assign nif.x2_out     = x2_q;
    assign nif.t_out      = t_q;
    assign nif.data_ready = data_ready_q;
    assign nif.n_out      = {{(32-AW-1){1'b0}}, count};

endmodule

// File: tb/tb_sample_feeder.sv
module tb_sample_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        load_en = 1'b0;
    logic [6:0]  load_x1 = '0;
    logic [6:0]  load_x2 = '0;
    logic [1:0]  load_t = '0;
    logic        load_full;
    logic        start = 1'b0;
    logic [15:0] epoch;
    logic        busy;
    logic        finished;

    int vectors = 0;
    int miscompares = 0;

    sample_feeder_if #(.XW(7), .TW(2)) nif ();

    sample_feeder #(.DEPTH(512), .AW(9), .XW(7), .TW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .load_en   (load_en),
        .load_x1   (load_x1),
        .load_x2   (load_x2),
        .load_t    (load_t),
        .load_full (load_full),
        .start     (start),
        .nif       (nif.master),
        .epoch     (epoch),
        .busy      (busy),
        .finished  (finished)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [6:0] a, input logic [6:0] b, input logic [1:0] t);
        load_x1 = a;
        load_x2 = b;
        load_t  = t;
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
    endtask

    // Sample i of the full-depth set.
    function automatic logic [15:0] big_sample(input int i);
        logic [8:0] v;
        v = 9'(i);
        return {v[6:0], v[8:2], (v[0] ? 2'b01 : 2'b11)};
    endfunction

    logic [6:0] e_x1 [3];
    logic [6:0] e_x2 [3];
    logic [1:0] e_t  [3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        nif.request_flag = 1'b0;
        nif.neuron_done  = 1'b0;
        e_x1[0] = 7'h05; e_x2[0] = 7'h7D; e_t[0] = 2'b01;
        e_x1[1] = 7'h79; e_x2[1] = 7'h02; e_t[1] = 2'b11;
        e_x1[2] = 7'h00; e_x2[2] = 7'h01; e_t[2] = 2'b01;

        tick();
        chk("rst_data_ready", 32'(nif.data_ready), 32'd0);
        chk("rst_n_out", nif.n_out, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();

        // start with empty store is ignored
        start = 1'b1; tick(); start = 1'b0;
        chk("empty_start_busy", 32'(busy), 32'd0);
        chk("empty_start_fin", 32'(finished), 32'd0);

        // three-sample stream with held request_flag
        for (int i = 0; i < 3; i++) load(e_x1[i], e_x2[i], e_t[i]);
        chk("n_out_3", nif.n_out, 32'd3);
        start = 1'b1; tick(); start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        nif.request_flag = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stream_dr_hi", 32'(nif.data_ready), 32'd1);
            chk("stream_x1", 32'(nif.x1_out), 32'(e_x1[k]));
            chk("stream_x2", 32'(nif.x2_out), 32'(e_x2[k]));
            chk("stream_t", 32'(nif.t_out), 32'(e_t[k]));
            chk("stream_epoch_pre", 32'(epoch), 32'd0);
            tick();
            chk("stream_dr_lo", 32'(nif.data_ready), 32'd0);
            chk("stream_epoch_post", 32'(epoch), (k == 2) ? 32'd1 : 32'd0);
        end
        tick();
        chk("wrap_dr", 32'(nif.data_ready), 32'd1);
        chk("wrap_x1", 32'(nif.x1_out), 32'(e_x1[0]));

        // async reset while in PRESENT
        rst = 1'b0;
        #1;
        chk("arst_dr", 32'(nif.data_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_n_out", nif.n_out, 32'd0);
        chk("arst_epoch", 32'(epoch), 32'd0);
        nif.request_flag = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // done vs request priority, restart from DONE
        load(7'h11, 7'h22, 2'b01);
        load(7'h33, 7'h44, 2'b11);
        start = 1'b1; tick(); start = 1'b0;
        nif.request_flag = 1'b1; tick(); nif.request_flag = 1'b0;
        chk("d_s0_x1", 32'(nif.x1_out), 32'h11);
        tick();
        load_en = 1'b1; load_x1 = 7'h7F; tick(); load_en = 1'b0;
        chk("load_in_wait_ignored", nif.n_out, 32'd2);
        nif.request_flag = 1'b1; tick();
        chk("d_s1_x1", 32'(nif.x1_out), 32'h33);
        tick();
        chk("d_epoch1", 32'(epoch), 32'd1);
        nif.neuron_done = 1'b1;
        tick();
        chk("done_no_dr", 32'(nif.data_ready), 32'd0);
        chk("done_finished", 32'(finished), 32'd1);
        chk("done_hold_x1", 32'(nif.x1_out), 32'h33);
        nif.neuron_done = 1'b0;
        nif.request_flag = 1'b0;
        tick();
        chk("done_stays", 32'(finished), 32'd1);
        chk("done_epoch_hold", 32'(epoch), 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_epoch", 32'(epoch), 32'd0);
        chk("restart_n_out", nif.n_out, 32'd2);
        nif.request_flag = 1'b1; tick(); nif.request_flag = 1'b0;
        chk("restart_x1", 32'(nif.x1_out), 32'h11);
        tick();

        // clear during WAIT_REQ
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_busy", 32'(busy), 32'd0);
        chk("clear_n_out", nif.n_out, 32'd0);
        load(7'h5A, 7'h06, 2'b11);
        chk("clear_reload_n", nif.n_out, 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        nif.request_flag = 1'b1; tick(); nif.request_flag = 1'b0;
        chk("clear_idx0_x1", 32'(nif.x1_out), 32'h5A);
        chk("clear_idx0_t", 32'(nif.t_out), 32'h3);
        tick();

        // fill to depth, overflow writes dropped
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 512; i++) begin
            s = big_sample(i);
            load(s[15:9], s[8:2], s[1:0]);
        end
        chk("full_flag", 32'(load_full), 32'd1);
        chk("full_n_out", nif.n_out, 32'd512);
        load(7'h2A, 7'h15, 2'b10);
        load(7'h2A, 7'h15, 2'b10);
        chk("overflow_n_out", nif.n_out, 32'd512);
        start = 1'b1; tick(); start = 1'b0;
        nif.request_flag = 1'b1;
        for (int i = 0; i < 512; i++) begin
            s = big_sample(i);
            tick();
            chk("big_x1", 32'(nif.x1_out), 32'(s[15:9]));
            if (i == 511) begin
                chk("big_last_x2", 32'(nif.x2_out), 32'(s[8:2]));
                chk("big_last_t", 32'(nif.t_out), 32'(s[1:0]));
            end
            tick();
        end
        chk("big_epoch", 32'(epoch), 32'd1);
        tick();
        s = big_sample(0);
        chk("big_wrap_x1", 32'(nif.x1_out), 32'(s[15:9]));
        chk("big_wrap_x2", 32'(nif.x2_out), 32'(s[8:2]));
        nif.request_flag = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
